i2c_master_ctrl: RTL

//  Single-transaction I2C controller: the initiator that drives our I2C slave. Generates SCL from the

---
 rtl/i2c_master_ctrl_pkg.sv | 34 +++
 rtl/i2c_master_ctrl_if.sv | 26 ++
 rtl/i2c_master_ctrl_scl_gen.sv | 36 +++
 rtl/i2c_master_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_ctrl_pkg.sv
// rtl/i2c_master_ctrl_pkg.sv - shared types and bus constants for the I2C controller
// Purpose: FSM state encoding, SCL phase names, ACK/NACK bus levels,
//          RW position and address-byte packing helper.
// Ports:   none (package).
package i2c_master_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RNACK,
    ST_STOP
  } state_t;

  // Quarter-periods of one bit-time.
  localparam logic [1:0] PH0 = 2'd0;  // SCL low, SDA updated
  localparam logic [1:0] PH1 = 2'd1;  // SCL high
  localparam logic [1:0] PH2 = 2'd2;  // SCL high, SDA sampled on last clock
  localparam logic [1:0] PH3 = 2'd3;  // SCL low

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;
  localparam logic RW_READ  = 1'b1;

  // Address byte goes out LSB first, so RW sits in bit 0 and leaves first.
  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// rtl/i2c_master_ctrl_if.sv - host command/status and SCL bundle for the I2C controller
// Purpose: groups the one-shot host command, status outputs and SCL.
// Signals: start, rw, addr_in, data_in (host -> controller);
//          busy, done, ack_err, data_out, scl (controller -> host/bus).
// Modports: master = the I2C controller, slave = host logic driving it.
interface i2c_master_ctrl_if;
  logic       start;
  logic       rw;
  logic [6:0] addr_in;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] data_out;
  logic       scl;

  modport master (
    input  start, rw, addr_in, data_in,
    output busy, done, ack_err, data_out, scl
  );

  modport slave (
    output start, rw, addr_in, data_in,
    input  busy, done, ack_err, data_out, scl
  );
endinterface

// File: rtl/i2c_master_ctrl_scl_gen.sv
// rtl/i2c_master_ctrl_scl_gen.sv - SCL divider and quarter-phase counter
// Purpose: divides clk into four CLK_DIV-clock phases per bit-time.
// Ports: clk, reset (sync, active high), en (held at PH0/count 0 while low),
//        phase (current quarter), phase_end (last clock of the current quarter).
module i2c_master_ctrl_scl_gen
  import i2c_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [1:0] phase,
  output logic       phase_end
);

  localparam int            DW       = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      div_cnt <= '0;
      phase   <= PH0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      phase   <= phase + 2'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign phase_end = en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-transaction I2C controller (START, addr, one byte, STOP)
// Purpose: accepts one command, runs START, address byte, one write or read byte
//          with optional ACK slots, then STOP; bytes go LSB first.
// Ports: clk, reset (sync, active high); bus (master modport: start/rw/addr_in/
//        data_in in, busy/done/ack_err/data_out/scl out); sda (open bus data,
//        driven only while the controller owns it, otherwise released to z).
module i2c_master_ctrl
  import i2c_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter bit ACK_SLOT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_master_ctrl_if.master     bus,
  inout  wire                   sda
);

  state_t     state, state_nx;
  logic [1:0] phase;
  logic       phase_end;
  logic       bit_end;
  logic       sample_now;
  logic       last_bit;
  logic       scl_high;
  state_t     data_st;

  logic [7:0] shreg;
  logic [7:0] wdata;
  logic       rw_q;
  logic [2:0] bit_cnt;
  logic       busy_q;
  logic       done_q;
  logic       ack_err_q;
  logic [7:0] data_out_q;

  logic       scl_c;
  logic       sda_o;
  logic       sda_drv;
  logic       sda_in;

  i2c_master_ctrl_scl_gen #(.CLK_DIV(CLK_DIV)) u_scl_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (state != ST_IDLE),
    .phase     (phase),
    .phase_end (phase_end)
  );

  assign bit_end    = phase_end && (phase == PH3);
  assign sample_now = phase_end && (phase == PH2);
  assign last_bit   = (bit_cnt == 3'd7);
  assign scl_high   = (phase == PH1) || (phase == PH2);
  assign data_st    = (rw_q == RW_READ) ? ST_RDATA : ST_WDATA;
  assign sda_in     = sda;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    scl_c    = 1'b1;
    sda_o    = 1'b1;
    sda_drv  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nx = ST_START;
      end
      ST_START: begin
        // SCL stays high; SDA falls at PH2 to form the START condition.
        sda_drv = 1'b1;
        sda_o   = ~phase[1];
        if (bit_end) state_nx = ST_ADDR;
      end
      ST_ADDR: begin
        scl_c   = scl_high;
        sda_drv = 1'b1;
        sda_o   = shreg[0];
        if (bit_end && last_bit) state_nx = ACK_SLOT ? ST_ADDR_ACK : data_st;
      end
      ST_ADDR_ACK: begin
        scl_c = scl_high;
        // A NACK here skips the data byte entirely.
        if (bit_end) state_nx = ack_err_q ? ST_STOP : data_st;
      end
      ST_WDATA: begin
        scl_c   = scl_high;
        sda_drv = 1'b1;
        sda_o   = shreg[0];
        if (bit_end && last_bit) state_nx = ACK_SLOT ? ST_WACK : ST_STOP;
      end
      ST_WACK: begin
        scl_c = scl_high;
        if (bit_end) state_nx = ST_STOP;
      end
      ST_RDATA: begin
        scl_c = scl_high;
        if (bit_end && last_bit) state_nx = ACK_SLOT ? ST_RNACK : ST_STOP;
      end
      ST_RNACK: begin
        // Single-byte read: tell the slave we want no more data.
        scl_c   = scl_high;
        sda_drv = 1'b1;
        sda_o   = SDA_NACK;
        if (bit_end) state_nx = ST_STOP;
      end
      ST_STOP: begin
        // SDA low under SCL low, SCL rises, then SDA rises while SCL high.
        scl_c   = (phase != PH0);
        sda_drv = 1'b1;
        sda_o   = phase[1];
        if (bit_end) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= 8'h00;
      wdata      <= 8'h00;
      rw_q       <= 1'b0;
      bit_cnt    <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (bus.start) begin
          shreg     <= addr_byte(bus.addr_in, bus.rw);
          wdata     <= bus.data_in;
          rw_q      <= bus.rw;
          bit_cnt   <= 3'd0;
          busy_q    <= 1'b1;
          ack_err_q <= 1'b0;
        end
      end else begin
        if (sample_now) begin
          if ((state == ST_ADDR_ACK || state == ST_WACK) && sda_in == SDA_NACK) begin
            ack_err_q <= 1'b1;
          end
          if (state == ST_RDATA) begin
            // First received bit ends up in bit 0 after eight shifts.
            shreg <= {sda_in, shreg[7:1]};
            if (last_bit) data_out_q <= {sda_in, shreg[7:1]};
          end
        end
        if (bit_end) begin
          if (state == ST_ADDR || state == ST_WDATA || state == ST_RDATA) begin
            bit_cnt <= bit_cnt + 3'd1;  // wraps 7 -> 0 at byte end
            if (state == ST_ADDR && last_bit) begin
              shreg <= wdata;
            end else if (state != ST_RDATA) begin
              shreg <= shreg >> 1;
            end
          end
          if (state == ST_STOP) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign sda          = sda_drv ? sda_o : 1'bz;
  assign bus.scl      = scl_c;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ack_err  = ack_err_q;
  assign bus.data_out = data_out_q;

endmodule
